// File: rtl/pal_csync_gen_if.sv
// ---------------------------------------------------------------------------
// pal_csync_gen_if
//
// Bundle between the PAL composite sync generator and its consumers. The
// consumers are the csync_scartOut driver and the RGB666 pixel path. Clock and
// reset are not part of the bundle. They are connected to the generator as
// plain ports.
//
// Signals:
//   pixelEn      consumer -> generator  one-cycle advance strobe (pixelClockX1_en)
//   csync        generator -> consumer  composite sync, active low
//   hsync        generator -> consumer  one-cycle pulse at the start of each line
//   vsync        generator -> consumer  high inside the field-sync region
//   field        generator -> consumer  0 for lines 1-312, 1 for lines 313-625
//   pixelX[10:0] generator -> consumer  horizontal position
//   lineNum[9:0] generator -> consumer  line number 1..625
//
// Optional signals, present only when CSYNC_GENLOCK_EN is defined:
//   genlockStart consumer -> generator  single-cycle restart to line 1, pixel 0
//   genlocked    generator -> consumer  sticky flag, set by the first genlock
//
// Modports: master = the generator, slave = the block that owns pixelEn.
// ---------------------------------------------------------------------------
interface pal_csync_gen_if;
  logic        pixelEn;
  logic        csync;
  logic        hsync;
  logic        vsync;
  logic        field;
  logic [10:0] pixelX;
  logic [9:0]  lineNum;

`ifdef CSYNC_GENLOCK_EN
  logic        genlockStart;
  logic        genlocked;

  modport master (
    input  pixelEn, genlockStart,
    output csync, hsync, vsync, field, pixelX, lineNum, genlocked
  );

  modport slave (
    output pixelEn, genlockStart,
    input  csync, hsync, vsync, field, pixelX, lineNum, genlocked
  );
`else
  modport master (
    input  pixelEn,
    output csync, hsync, vsync, field, pixelX, lineNum
  );

  modport slave (
    output pixelEn,
    input  csync, hsync, vsync, field, pixelX, lineNum
  );
`endif
endinterface

// File: rtl/pal_csync_gen.sv
// ---------------------------------------------------------------------------
// pal_csync_gen
//
// This block generates an interlaced PAL composite sync (active low). The
// frame has 625 lines in a 2:1 interlace. The block is the companion of the
// csync_edges / csync_to_hsync decode path. That path decodes incoming csync.
// This block produces csync for csync_scartOut. It also produces hsync,
// vsync, field and the pixel/line coordinates for the RGB666 pixel path.
//
// The block runs in the pixelClockX6_out domain. It advances only on cycles
// where pixelEn (pixelClockX1_en) is high.
//
// Ports:
//   sysClock  input   system clock (pixelClockX6_out)
//   nReset    input   asynchronous active-low reset
//   sync_bus  master  pal_csync_gen_if:
//                     pixelEn in; csync, hsync, vsync, field, pixelX, lineNum out
//
// Parameters:
//   H_TOTAL  pixel enables per line. Must be even.
//   HSYNC_W  low width of a normal line-sync pulse
//   EQ_W     low width of an equalising pulse
//   BROAD_W  low width of a broad pulse
//
// Optional feature, controlled by the macro CSYNC_GENLOCK_EN:
//   The interface then carries genlockStart and genlocked. A genlockStart
//   pulse restarts the raster at line 1, pixel 0, on that sysClock edge. It
//   overrides a pixelEn on the same edge. genlocked goes high on the first
//   genlock and stays high until reset. When the macro is not defined, the
//   generator is free-running and neither signal exists.
// ---------------------------------------------------------------------------
module pal_csync_gen #(
  parameter int H_TOTAL = 1024,
  parameter int HSYNC_W = 75,
  parameter int EQ_W    = 38,
  parameter int BROAD_W = 437
) (
  input  logic            sysClock,
  input  logic            nReset,
  pal_csync_gen_if.master sync_bus
);

  localparam int HALF = H_TOTAL / 2;

  // Each half line (slot) carries at most one sync pulse, of one of these kinds.
  typedef enum logic [1:0] {
    SLOT_N,   // normal line sync
    SLOT_E,   // equalising pulse
    SLOT_B,   // broad (field-sync) pulse
    SLOT_X    // no pulse
  } slot_kind_e;

  // Raster position.
  logic [10:0] pixel_x;
  logic [10:0] pixel_next;
  logic [10:0] half_pos;
  logic [10:0] half_next;
  logic        slot_b;
  logic        slot_b_next;
  logic [9:0]  line_num;
  logic [9:0]  line_next;
  logic        field_q;
  logic        field_next;

  // Registered outputs.
  logic        csync_q;
  logic        vsync_q;
  logic        hsync_q;

  // Misc.
  logic        genlock_hit;
  logic        advance;
  logic        moved;
  slot_kind_e  slot_kind;
  int          pulse_w;
  logic        pulse_low;
  logic        in_vsync;

`ifdef CSYNC_GENLOCK_EN
  logic        genlocked_q;
  assign genlock_hit = sync_bus.genlockStart;
`else
  assign genlock_hit = 1'b0;
`endif

  // The position changes on pixelEn, or on a genlock restart.
  assign advance = sync_bus.pixelEn | genlock_hit;

  // Next raster position.
  // half_pos counts within the current half line and slot_b selects the
  // second half. Both are kept as their own counter, so H_TOTAL does not have
  // to be a power of two. The field flag is derived from the new line number,
  // so it changes on the same enable as the line does.
  always_comb begin
    pixel_next  = pixel_x;
    half_next   = half_pos;
    slot_b_next = slot_b;
    line_next   = line_num;
    field_next  = field_q;

    if (genlock_hit) begin
      pixel_next  = '0;
      half_next   = '0;
      slot_b_next = 1'b0;
      line_next   = 10'd1;
      field_next  = 1'b0;
    end else if (sync_bus.pixelEn) begin
      if (int'(pixel_x) >= H_TOTAL - 1) begin
        pixel_next  = '0;
        half_next   = '0;
        slot_b_next = 1'b0;
        line_next   = (line_num >= 10'd625) ? 10'd1 : line_num + 10'd1;
        field_next  = (line_next >= 10'd313);
      end else begin
        pixel_next = pixel_x + 11'd1;
        if (int'(half_pos) >= HALF - 1) begin
          half_next   = '0;
          slot_b_next = 1'b1;
        end else begin
          half_next = half_pos + 11'd1;
        end
      end
    end
  end

  // Raster counters, plus a flag that records whether they moved on this edge.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      pixel_x  <= '0;
      half_pos <= '0;
      slot_b   <= 1'b0;
      line_num <= 10'd1;
      field_q  <= 1'b0;
      moved    <= 1'b0;
    end else begin
      pixel_x  <= pixel_next;
      half_pos <= half_next;
      slot_b   <= slot_b_next;
      line_num <= line_next;
      field_q  <= field_next;
      moved    <= advance;
    end
  end

  // Look up the pulse kind for the current half line. Line ranges run in
  // order through both fields. Lines 311-318 and 623-625 contain the odd
  // half-line pulses that give the interlace.
  always_comb begin
    slot_kind = SLOT_X;
    if (line_num <= 10'd2) begin
      slot_kind = SLOT_B;
    end else if (line_num == 10'd3) begin
      slot_kind = slot_b ? SLOT_E : SLOT_B;
    end else if (line_num <= 10'd5) begin
      slot_kind = SLOT_E;
    end else if (line_num <= 10'd310) begin
      slot_kind = slot_b ? SLOT_X : SLOT_N;
    end else if (line_num <= 10'd312) begin
      slot_kind = SLOT_E;
    end else if (line_num == 10'd313) begin
      slot_kind = slot_b ? SLOT_B : SLOT_E;
    end else if (line_num <= 10'd315) begin
      slot_kind = SLOT_B;
    end else if (line_num <= 10'd317) begin
      slot_kind = SLOT_E;
    end else if (line_num == 10'd318) begin
      slot_kind = slot_b ? SLOT_X : SLOT_E;
    end else if (line_num <= 10'd622) begin
      slot_kind = slot_b ? SLOT_X : SLOT_N;
    end else if (line_num == 10'd623) begin
      slot_kind = slot_b ? SLOT_E : SLOT_N;
    end else begin
      slot_kind = SLOT_E;
    end
  end

  // The pulse is low from the start of the slot for pulse_w enables. A slot
  // with no pulse uses width 0, which never compares true. So does a width
  // parameter set to 0.
  always_comb begin
    pulse_w = 0;
    case (slot_kind)
      SLOT_N:  pulse_w = HSYNC_W;
      SLOT_E:  pulse_w = EQ_W;
      SLOT_B:  pulse_w = BROAD_W;
      default: pulse_w = 0;
    endcase
    pulse_low = (int'(half_pos) < pulse_w);
  end

  // Field-sync region: lines 1-5 and 623-625 for the first field, and lines
  // 311-317 for the second field.
  always_comb begin
    in_vsync = (line_num <= 10'd5) ||
               ((line_num >= 10'd311) && (line_num <= 10'd317)) ||
               (line_num >= 10'd623);
  end

  // csync and vsync are refreshed one sysClock after the counters move. They
  // hold while pixelEn is idle. After reset they therefore stay at their idle
  // values until the first enable. hsync marks the cycle after pixelX arrives
  // at 0. Because of the 'moved' qualifier, an idle pixelX=0 after reset does
  // not produce a pulse.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      csync_q <= 1'b1;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      if (moved) begin
        csync_q <= ~pulse_low;
        vsync_q <= in_vsync;
      end
      hsync_q <= moved && (pixel_x == 11'd0);
    end
  end

`ifdef CSYNC_GENLOCK_EN
  // Sticky indication that the raster has been aligned to an external field start.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      genlocked_q <= 1'b0;
    end else if (genlock_hit) begin
      genlocked_q <= 1'b1;
    end
  end

  assign sync_bus.genlocked = genlocked_q;
`endif

  assign sync_bus.csync   = csync_q;
  assign sync_bus.hsync   = hsync_q;
  assign sync_bus.vsync   = vsync_q;
  assign sync_bus.field   = field_q;
  assign sync_bus.pixelX  = pixel_x;
  assign sync_bus.lineNum = line_num;

endmodule

// File: tb/tb_pal_csync_gen.sv
// ---------------------------------------------------------------------------
// tb_pal_csync_gen
//
// Self-checking bench for pal_csync_gen. The bench uses a short line
// (H_TOTAL=32) so that more than one full 625-line frame fits in a short run.
// The pulse widths are scaled to match that line length. A behavioural model
// holds the raster position and the expected registered outputs as plain
// integers. It computes the pulse shapes from a per-line slot table. On every
// falling clock edge the outputs of the DUT are compared with the model.
// Literal expectations taken from the full-size 1024-pixel timing pin the
// model's pulse arithmetic. Further literal expectations pin the DUT at the
// reset, line-6, line-313, frame-wrap, hold and genlock points.
// ---------------------------------------------------------------------------
module tb_pal_csync_gen;

  localparam int H  = 32;
  localparam int HS = 5;
  localparam int EQ = 3;
  localparam int BR = 11;

  logic sysClock = 1'b0;
  logic nReset   = 1'b1;

  int n_vec    = 0;
  int n_fail   = 0;
  int hs_count = 0;
  bit check_on = 1'b0;

  // Model state.
  int m_px;
  int m_line;
  int m_abs;
  bit m_moved;
  bit m_csync;
  bit m_vsync;
  bit m_hsync;
  bit m_glk;

  // Slot table, one pulse kind per half line: "N", "E", "B" or "X".
  byte slot_a [1:625];
  byte slot_b [1:625];

  pal_csync_gen_if bus ();

  pal_csync_gen #(
    .H_TOTAL (H),
    .HSYNC_W (HS),
    .EQ_W    (EQ),
    .BROAD_W (BR)
  ) dut (
    .sysClock (sysClock),
    .nReset   (nReset),
    .sync_bus (bus)
  );

  always #5 sysClock = ~sysClock;

  function automatic void setLines(input int lo, input int hi, input byte a, input byte b);
    for (int l = lo; l <= hi; l++) begin
      slot_a[l] = a;
      slot_b[l] = b;
    end
  endfunction

  function automatic void buildTables();
    setLines(1,   2,   "B", "B");
    setLines(3,   3,   "B", "E");
    setLines(4,   5,   "E", "E");
    setLines(6,   310, "N", "X");
    setLines(311, 312, "E", "E");
    setLines(313, 313, "E", "B");
    setLines(314, 315, "B", "B");
    setLines(316, 317, "E", "E");
    setLines(318, 318, "E", "X");
    setLines(319, 622, "N", "X");
    setLines(623, 623, "N", "E");
    setLines(624, 625, "E", "E");
  endfunction

  // Returns 1 if csync must be low at position (line, px) for the given timing.
  function automatic bit expLow(input int h, input int hs, input int eq, input int br,
                                input int line, input int px);
    int  half = h / 2;
    int  s    = px % half;
    byte k    = (px < half) ? slot_a[line] : slot_b[line];
    int  w;
    case (k)
      "N":     w = hs;
      "E":     w = eq;
      "B":     w = br;
      default: w = 0;
    endcase
    return s < w;
  endfunction

  function automatic int countLow(input int h, input int hs, input int eq, input int br,
                                  input int line);
    int n = 0;
    for (int p = 0; p < h; p++) n += int'(expLow(h, hs, eq, br, line, p));
    return n;
  endfunction

  function automatic bit inVsync(input int line);
    return (line <= 5) || (line >= 311 && line <= 317) || (line >= 623);
  endfunction

  function automatic void resetModel();
    m_px    = 0;
    m_line  = 1;
    m_abs   = 1;
    m_moved = 1'b0;
    m_csync = 1'b1;
    m_vsync = 1'b0;
    m_hsync = 1'b0;
    m_glk   = 1'b0;
  endfunction

  // Advance the model across one rising edge. The registered outputs show the
  // position reached on the previous edge, but only if the raster moved then.
  function automatic void modelStep(input bit en, input bit gl);
    if (!nReset) return;
    m_hsync = m_moved && (m_px == 0);
    if (m_moved) begin
      m_csync = !expLow(H, HS, EQ, BR, m_line, m_px);
      m_vsync = inVsync(m_line);
    end
    m_moved = en || gl;
    if (gl) begin
      m_px   = 0;
      m_line = 1;
      m_abs  = 1;
      m_glk  = 1'b1;
    end else if (en) begin
      m_px++;
      if (m_px == H) begin
        m_px   = 0;
        m_line = (m_line % 625) + 1;
        m_abs++;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (model line %0d px %0d, t=%0t)",
               name, got, exp, m_line, m_px, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit gl);
    bus.pixelEn = en;
`ifdef CSYNC_GENLOCK_EN
    bus.genlockStart = gl;
`endif
    @(posedge sysClock);
    modelStep(en, gl);
    #1;
  endtask

  // Drive random enables until the model reaches the absolute line and pixel given.
  task automatic runUntil(input int abs_line, input int px);
    int n = 0;
    while (!(m_abs == abs_line && m_px == px) && n < 60000) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'b0);
      n++;
    end
    if (!(m_abs == abs_line && m_px == px)) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL runUntil: reached line %0d px %0d, wanted line %0d px %0d",
               m_abs, m_px, abs_line, px);
    end
    bus.pixelEn = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pixelX"},  32'(bus.pixelX),  32'd0);
    checkOutput({tag, "_lineNum"}, 32'(bus.lineNum), 32'd1);
    checkOutput({tag, "_field"},   32'(bus.field),   32'd0);
    checkOutput({tag, "_csync"},   32'(bus.csync),   32'd1);
    checkOutput({tag, "_hsync"},   32'(bus.hsync),   32'd0);
    checkOutput({tag, "_vsync"},   32'(bus.vsync),   32'd0);
  endtask

  // Pin the model to hand-derived full-size (1024-pixel) pulse shapes.
  task automatic pinModel();
    checkOutput("pin_l6_count",   32'(countLow(1024, 75, 38, 437, 6)),   32'd75);
    checkOutput("pin_l6_px74",    32'(expLow(1024, 75, 38, 437, 6, 74)),  32'd1);
    checkOutput("pin_l6_px75",    32'(expLow(1024, 75, 38, 437, 6, 75)),  32'd0);
    checkOutput("pin_l6_px512",   32'(expLow(1024, 75, 38, 437, 6, 512)), 32'd0);
    checkOutput("pin_l313_count", 32'(countLow(1024, 75, 38, 437, 313)), 32'd475);
    checkOutput("pin_l313_px38",  32'(expLow(1024, 75, 38, 437, 313, 38)),  32'd0);
    checkOutput("pin_l313_px948", 32'(expLow(1024, 75, 38, 437, 313, 948)), 32'd1);
    checkOutput("pin_l313_px949", 32'(expLow(1024, 75, 38, 437, 313, 949)), 32'd0);
    checkOutput("pin_l1_count",   32'(countLow(1024, 75, 38, 437, 1)),   32'd874);
    checkOutput("pin_l623_count", 32'(countLow(1024, 75, 38, 437, 623)), 32'd113);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge sysClock) begin
    if (check_on) begin
      checkOutput("csync",   32'(bus.csync),   32'(m_csync));
      checkOutput("hsync",   32'(bus.hsync),   32'(m_hsync));
      checkOutput("vsync",   32'(bus.vsync),   32'(m_vsync));
      checkOutput("field",   32'(bus.field),   32'(m_line >= 313));
      checkOutput("pixelX",  32'(bus.pixelX),  32'(m_px));
      checkOutput("lineNum", 32'(bus.lineNum), 32'(m_line));
`ifdef CSYNC_GENLOCK_EN
      checkOutput("genlocked", 32'(bus.genlocked), 32'(m_glk));
`endif
      if (bus.hsync === 1'b1) hs_count++;
    end
  end

  initial begin
    #990000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs0;
    buildTables();
    pinModel();
    bus.pixelEn = 1'b0;
`ifdef CSYNC_GENLOCK_EN
    bus.genlockStart = 1'b0;
`endif
    #2;
    nReset = 1'b0;
    resetModel();
    #1;
    check_on = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b0);
    checkResetValues("reset");
    nReset = 1'b1;

    // Four enables directly after reset: the broad pulse of line 1 is under way.
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("first4_pixelX",  32'(bus.pixelX),  32'd4);
    checkOutput("first4_lineNum", 32'(bus.lineNum), 32'd1);
    checkOutput("first4_csync",   32'(bus.csync),   32'd0);
    checkOutput("first4_vsync",   32'(bus.vsync),   32'd1);
    checkOutput("first4_field",   32'(bus.field),   32'd0);

    // Line 6: normal sync in slot A, no pulse in slot B.
    runUntil(6, 4);
    checkOutput("l6_syncLow",   32'(bus.csync), 32'd0);
    runUntil(6, 18);
    checkOutput("l6_slotBHigh", 32'(bus.csync), 32'd1);

    // Hold pixelEn low mid-line 100: everything freezes.
    runUntil(100, 10);
    repeat (100) applyStimulus(1'b0, 1'b0);
    checkOutput("hold_pixelX",  32'(bus.pixelX),  32'd10);
    checkOutput("hold_lineNum", 32'(bus.lineNum), 32'd100);
    checkOutput("hold_csync",   32'(bus.csync),   32'd1);

    // Line 313: second field, broad pulse in slot B.
    runUntil(313, 20);
    checkOutput("l313_lineNum", 32'(bus.lineNum), 32'd313);
    checkOutput("l313_field",   32'(bus.field),   32'd1);
    checkOutput("l313_vsync",   32'(bus.vsync),   32'd1);
    checkOutput("l313_broadB",  32'(bus.csync),   32'd0);

    // Frame wrap 625 -> 1.
    runUntil(625, 30);
    hs0 = hs_count;
    runUntil(626, 3);
    checkOutput("wrap_hsyncPulses", 32'(hs_count - hs0), 32'd1);
    checkOutput("wrap_lineNum",     32'(bus.lineNum),    32'd1);
    checkOutput("wrap_field",       32'(bus.field),      32'd0);
    checkOutput("wrap_broadA",      32'(bus.csync),      32'd0);
    runUntil(626, 18);
    checkOutput("wrap_broadB",      32'(bus.csync),      32'd0);

    // Asynchronous reset mid-line 200 of the second frame.
    runUntil(825, 2);
    nReset = 1'b0;
    #1;
    checkResetValues("midReset");
    resetModel();
    repeat (3) applyStimulus($urandom_range(0, 1) != 0, 1'b0);
    nReset = 1'b1;
    repeat (20) applyStimulus($urandom_range(0, 3) != 0, 1'b0);

`ifdef CSYNC_GENLOCK_EN
    // Genlock coinciding with pixelEn at line 400 restarts the raster.
    runUntil(400, 9);
    applyStimulus(1'b1, 1'b1);
    checkOutput("glk_pixelX",    32'(bus.pixelX),    32'd0);
    checkOutput("glk_lineNum",   32'(bus.lineNum),   32'd1);
    checkOutput("glk_field",     32'(bus.field),     32'd0);
    checkOutput("glk_genlocked", 32'(bus.genlocked), 32'd1);
    repeat (40) applyStimulus($urandom_range(0, 3) != 0, 1'b0);
`endif

    @(posedge sysClock);
    #1;
    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pal_csync_gen.md
Name: pal_csync_gen

Overview:
- Generates a 625-line, 2:1 interlaced PAL composite sync (active-low) from counters running on the pixel-clock enable.
- Companion to the csync_edges / csync_to_hsync decode path: that path decodes incoming AIV csync; this block produces csync for csync_scartOut.
- Also outputs hsync, vsync, field and pixel/line coordinates for the RGB666 pixel path.
- Sits in the pixelClockX6_out domain, advancing only on pixelClockX1_en.

Parameters:
- H_TOTAL, 1024: pixel enables per line (64 us at 16 MHz); must be even.
- HSYNC_W, 75: normal line-sync low width (4.7 us).
- EQ_W, 38: equalising pulse low width (2.35 us).
- BROAD_W, 437: broad pulse low width (H_TOTAL/2 - HSYNC_W).

Ports:
- sysClock  input  1  system clock (pixelClockX6_out).
- nReset  input  1  asynchronous active-low reset.
- pixelEn  input  1  one-cycle advance strobe (pixelClockX1_en).
- csync  output  1  composite sync, active low.
- hsync  output  1  one-sysClock pulse at the start of every line (x==0).
- vsync  output  1  high while in the field-sync region (field 0: lines 1-5 and 623-625; field 1: lines 311-317).
- field  output  1  0 for lines 1-312, 1 for lines 313-625.
- pixelX  output  11  horizontal count, 0..H_TOTAL-1.
- lineNum  output  10  line number, 1..625.

Behaviour:
- Reset (async assert, sync release):
  - pixelX=0, lineNum=1, field=0, csync=1, hsync=0, vsync=0.
  - Internal half-line and line counters clear.
- Counting:
  - pixelX increments only on cycles with pixelEn=1.
  - At H_TOTAL-1 it wraps to 0 and lineNum increments.
  - lineNum 625 wraps to 1; field updates on the same pixelEn as the lineNum change.
  - With pixelEn=0 all state holds.
- Half-line slots: slot A is pixelX < H_TOTAL/2; slot B is the rest. s = pixelX mod H_TOTAL/2. Each slot has one type:
  - N: low for s < HSYNC_W.
  - E: low for s < EQ_W.
  - B: low for s < BROAD_W.
  - X: no pulse.
- Slot table (A/B):
  - Lines 1-2: B/B. Line 3: B/E. Lines 4-5: E/E.
  - Lines 6-310: N/X.
  - Lines 311-312: E/E. Line 313: E/B. Lines 314-315: B/B. Lines 316-317: E/E. Line 318: E/X.
  - Lines 319-622: N/X.
  - Line 623: N/E. Lines 624-625: E/E.
- Latency:
  - csync and vsync are registered, one sysClock after the pixelEn cycle that moves the counters into the new state.
  - hsync is a one-cycle pulse, registered, on the cycle after pixelX becomes 0.
- Counters are compared in full width; a comparison with a parameter at 0 never asserts.
- A reset asserted mid-line forces the reset values immediately. After release, the first pixelEn moves pixelX to 1 on line 1, so csync goes low for the broad pulse.

Optional Feature:
- Macro: CSYNC_GENLOCK_EN.
- Enabled:
  - Extra input genlockStart (1 bit, sysClock domain, single-cycle pulse, e.g. from the AIV field-start detector).
  - On genlockStart=1: pixelX<=0, lineNum<=1, field<=0 on that sysClock edge, regardless of pixelEn.
  - If genlockStart and pixelEn coincide, genlock wins.
  - An output genlocked goes high and stays high until reset.
- Disabled: no port; free-running only; the genlocked output is absent.

Test Plan:
- Reset then 4 pixelEn pulses -> csync=0 from the first enable, pixelX=4, lineNum=1, vsync=1, field=0.
- Run to line 6 -> csync low for exactly 75 enables at pixelX 0..74, high for the remaining 949; no pulse at pixelX=512.
- Line 313 -> low for 38 enables at pixelX 0, then 437 enables from pixelX 512; field=1 and vsync=1.
- Line 625 to line 1 wrap -> hsync pulses once, lineNum=1, field=0; csync low 437 enables at both pixelX 0 and 512.
- Hold pixelEn=0 for 100 cycles mid-line 100 -> pixelX, lineNum and csync unchanged; assert nReset mid-line 200 -> all outputs at reset values within the same cycle.
- With CSYNC_GENLOCK_EN defined: genlockStart at line 400, pixelX=300 -> next cycle pixelX=0, lineNum=1, field=0, genlocked=1.
